// File: rtl/shift_pkg.sv
// Shared definitions for the bit-serial link: direction encoding, counter sizing
// and the receive buffer state.
package shift_pkg;

    localparam logic DIR_RTL = 1'b1;
    localparam logic DIR_LTR = 1'b0;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // Bit counter width for a given word width; used by transmitter and receiver alike.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_in_stage.sv
// Serial input shifter: gathers WIDTH bits and emits a single-cycle done pulse
// together with the completed word, combinationally on the completing edge.
module shift_in_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             si_i,
    input  logic             sv_i,
    input  logic             rtl_i,
    output logic             done_o,
    output logic [WIDTH-1:0] word_o,
    output logic             busy_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             eff_dir_s;

    // The first bit of a word uses the live direction; later bits use the latched one.
    always_comb begin
        s_d       = s_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        eff_dir_s = dir_q;
        if (sv_i) begin
            if (cnt_q == {CW{1'b0}}) begin
                eff_dir_s = rtl_i;
                dir_d     = rtl_i;
            end else begin
                eff_dir_s = dir_q;
                dir_d     = dir_q;
            end
            if (eff_dir_s == DIR_RTL) begin
                s_d = {s_q[WIDTH-2:0], si_i};
            end else begin
                s_d = {si_i, s_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            s_d   = s_q;
            cnt_d = cnt_q;
            dir_d = dir_q;
        end
        busy_d = (cnt_d != {CW{1'b0}});
    end

    // Shifter, counter and direction state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q    <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_LTR;
            busy_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = sv_i && (cnt_q == CNT_LAST);
    assign word_o = s_d;
    assign busy_o = busy_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver with a one-deep output buffer,
// valid/acknowledge handshake and sticky overflow flag.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             SI,
    input  logic             SV,
    input  logic             RTL,
    input  logic             A,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             V,
    output logic             BUSY,
    output logic             OVF
);

    logic             done_s;
    logic [WIDTH-1:0] word_s;

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] nq_q;
    logic             ovf_q, ovf_d;

    shift_in_stage #(.WIDTH(WIDTH)) u_in (
        .clk_i  (C),
        .rst_i  (R),
        .si_i   (SI),
        .sv_i   (SV),
        .rtl_i  (RTL),
        .done_o (done_s),
        .word_o (word_s),
        .busy_o (BUSY)
    );

    // Buffer state and output registers; nQ is registered alongside Q.
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= EMPTY;
            q_q     <= '0;
            nq_q    <= '1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            nq_q    <= ~q_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next buffer state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (done_s) state_d = FULL;
                else        state_d = EMPTY;
            end
            FULL: begin
                if (A && !done_s) state_d = EMPTY;
                else              state_d = FULL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Word capture and overflow: a completion into an unacknowledged FULL buffer is dropped.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        case (state_q)
            EMPTY: begin
                if (done_s) q_d = word_s;
                else        q_d = q_q;
            end
            FULL: begin
                if (done_s && A) begin
                    q_d = word_s;
                end else if (done_s) begin
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q;
                end
            end
            default: begin
                q_d   = q_q;
                ovf_d = ovf_q;
            end
        endcase
    end

    assign Q   = q_q;
    assign nQ  = nq_q;
    assign V   = (state_q == FULL);
    assign OVF = ovf_q;

endmodule
